// File: rtl/input_channel_lookahead_buffer_pkg.sv
// Shared interconnect constants for the input-channel lookahead buffers.
// Channel/tag/word sizing plus lookahead depth and reservation defaults.
package input_channel_lookahead_buffer_pkg;

  localparam int TIA_NUM_INPUT_CHANNELS = 4;
  localparam int TIA_TAG_WIDTH          = 4;
  localparam int TIA_WORD_WIDTH         = 32;

  localparam int LAB_DEPTH       = 4;
  localparam int LAB_MAX_PENDING = 2;

  localparam int LAB_PTR_W  = $clog2(LAB_DEPTH);
  localparam int LAB_CNT_W  = $clog2(LAB_DEPTH + 1);
  localparam int LAB_PEND_W = $clog2(LAB_MAX_PENDING + 1);

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int lab_cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_channel_lookahead_buffer_lane.sv
// One channel: circular buffer with reserve/commit lookahead window.
// Outputs are combinational from registered state; enq_ready = not full.
module input_channel_lookahead_lane
  import input_channel_lookahead_buffer_pkg::*;
#(
  parameter int DEPTH       = LAB_DEPTH,
  parameter int MAX_PENDING = LAB_MAX_PENDING,
  parameter int TAG_WIDTH   = TIA_TAG_WIDTH,
  parameter int WORD_WIDTH  = TIA_WORD_WIDTH,
  parameter int PEND_W      = lab_cnt_width(MAX_PENDING)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [TAG_WIDTH-1:0]  enq_tag,
  input  logic [WORD_WIDTH-1:0] enq_data,
  input  logic                  reserve,
  input  logic                  commit,
  output logic [TAG_WIDTH-1:0]  head_tag,
  output logic [WORD_WIDTH-1:0] head_data,
  output logic                  lookahead_valid,
  output logic [TAG_WIDTH-1:0]  lookahead_tag,
  output logic [PEND_W-1:0]     pending_count,
  output logic                  protocol_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = lab_cnt_width(DEPTH);

  logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
  logic [WORD_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              err_q, err_d;

  logic             enq_fire;
  logic             reserve_legal;
  logic             commit_legal;
  logic [PTR_W-1:0] la_idx;

  assign enq_ready       = (count_q < CNT_W'(DEPTH));
  assign enq_fire        = enq_valid && enq_ready;
  assign lookahead_valid = (count_q > CNT_W'(pending_q));
  // Truncation gives the modulo-DEPTH wrap; a full window has no valid lookahead anyway.
  assign la_idx          = rd_ptr_q + PTR_W'(pending_q);
  assign lookahead_tag   = tag_mem[la_idx];
  assign head_tag        = tag_mem[rd_ptr_q];
  assign head_data       = data_mem[rd_ptr_q];
  assign pending_count   = pending_q;
  assign protocol_error  = err_q;

  assign reserve_legal = lookahead_valid && (pending_q < PEND_W'(MAX_PENDING));
  assign commit_legal  = (pending_q != '0);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;
    err_d     = err_q;

    if (enq_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (commit && commit_legal) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq_fire && !(commit && commit_legal)) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq_fire && commit && commit_legal) begin
      count_d = count_q - CNT_W'(1);
    end

    // Flush wins over any reserve; a legal commit still pops the buffer.
    if (flush) begin
      pending_d = '0;
    end else if ((reserve && reserve_legal) && !(commit && commit_legal)) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (!(reserve && reserve_legal) && (commit && commit_legal)) begin
      pending_d = pending_q - PEND_W'(1);
    end

    if ((reserve && !reserve_legal) || (commit && !commit_legal)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      tag_mem[wr_ptr_q]  <= enq_tag;
      data_mem[wr_ptr_q] <= enq_data;
    end
  end

endmodule

// File: rtl/input_channel_lookahead_buffer.sv
// Per-channel lookahead buffers: one lane per input channel, shared flush.
// Zero-latency lookahead outputs; enq_ready deasserts when a channel is full.
module input_channel_lookahead_buffer
  import input_channel_lookahead_buffer_pkg::*;
#(
  parameter int NUM_CHANNELS = TIA_NUM_INPUT_CHANNELS,
  parameter int DEPTH        = LAB_DEPTH,
  parameter int MAX_PENDING  = LAB_MAX_PENDING,
  parameter int TAG_WIDTH    = TIA_TAG_WIDTH,
  parameter int WORD_WIDTH   = TIA_WORD_WIDTH,
  parameter int PEND_W       = lab_cnt_width(MAX_PENDING)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CHANNELS-1:0]                 enq_valid,
  output logic [NUM_CHANNELS-1:0]                 enq_ready,
  input  logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  enq_tag,
  input  logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] enq_data,
  input  logic [NUM_CHANNELS-1:0]                 reserve,
  input  logic [NUM_CHANNELS-1:0]                 commit,
  input  logic                                    flush,
  output logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  head_tag,
  output logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] head_data,
  output logic [NUM_CHANNELS-1:0]                 lookahead_valid,
  output logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  lookahead_tag,
  output logic [NUM_CHANNELS-1:0][PEND_W-1:0]     pending_count,
  output logic [NUM_CHANNELS-1:0]                 protocol_error
);

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_lane
    input_channel_lookahead_lane #(
      .DEPTH       (DEPTH),
      .MAX_PENDING (MAX_PENDING),
      .TAG_WIDTH   (TAG_WIDTH),
      .WORD_WIDTH  (WORD_WIDTH),
      .PEND_W      (PEND_W)
    ) u_lane (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .enq_valid       (enq_valid[ch]),
      .enq_ready       (enq_ready[ch]),
      .enq_tag         (enq_tag[ch]),
      .enq_data        (enq_data[ch]),
      .reserve         (reserve[ch]),
      .commit          (commit[ch]),
      .head_tag        (head_tag[ch]),
      .head_data       (head_data[ch]),
      .lookahead_valid (lookahead_valid[ch]),
      .lookahead_tag   (lookahead_tag[ch]),
      .pending_count   (pending_count[ch]),
      .protocol_error  (protocol_error[ch])
    );
  end

endmodule

// File: tb/tb_input_channel_lookahead_buffer.sv
// Directed bench for input_channel_lookahead_buffer with hand-computed expectations.
module tb_input_channel_lookahead_buffer;
  import input_channel_lookahead_buffer_pkg::*;

  localparam int NC = TIA_NUM_INPUT_CHANNELS;
  localparam int TW = TIA_TAG_WIDTH;
  localparam int WW = TIA_WORD_WIDTH;
  localparam int PW = lab_cnt_width(LAB_MAX_PENDING);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NC-1:0]          enq_valid = '0;
  logic [NC-1:0]          enq_ready;
  logic [NC-1:0][TW-1:0]  enq_tag = '0;
  logic [NC-1:0][WW-1:0]  enq_data = '0;
  logic [NC-1:0]          reserve = '0;
  logic [NC-1:0]          commit = '0;
  logic                   flush = 1'b0;
  logic [NC-1:0][TW-1:0]  head_tag;
  logic [NC-1:0][WW-1:0]  head_data;
  logic [NC-1:0]          lookahead_valid;
  logic [NC-1:0][TW-1:0]  lookahead_tag;
  logic [NC-1:0][PW-1:0]  pending_count;
  logic [NC-1:0]          protocol_error;

  int n_cmp = 0;
  int n_err = 0;

  input_channel_lookahead_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .enq_valid       (enq_valid),
    .enq_ready       (enq_ready),
    .enq_tag         (enq_tag),
    .enq_data        (enq_data),
    .reserve         (reserve),
    .commit          (commit),
    .flush           (flush),
    .head_tag        (head_tag),
    .head_data       (head_data),
    .lookahead_valid (lookahead_valid),
    .lookahead_tag   (lookahead_tag),
    .pending_count   (pending_count),
    .protocol_error  (protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = '0;
    reserve   = '0;
    commit    = '0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic enq0(input int t);
    enq_valid[0] = 1'b1;
    enq_tag[0]   = TW'(t);
    enq_data[0]  = WW'(t * 100);
    cyc();
    enq_valid[0] = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_enq_ready", 32'(enq_ready), 32'hF);
    check("rst_la_valid", 32'(lookahead_valid), 32'h0);
    check("rst_pending", 32'(pending_count), 32'h0);
    check("rst_err", 32'(protocol_error), 32'h0);
    cyc();
    reset = 1'b0;
    #1;

    // Fill channel 0; first entry visible one cycle after its write edge
    enq0(1);
    check("fill_la_valid_1", 32'(lookahead_valid[0]), 32'd1);
    check("fill_la_tag_1", 32'(lookahead_tag[0]), 32'd1);
    for (int t = 2; t <= 4; t++) enq0(t);
    check("fill_enq_ready", 32'(enq_ready[0]), 32'd0);
    check("fill_head_tag", 32'(head_tag[0]), 32'd1);
    check("fill_head_data", head_data[0], 32'd100);
    check("fill_la_tag", 32'(lookahead_tag[0]), 32'd1);
    check("fill_la_valid", 32'(lookahead_valid[0]), 32'd1);
    check("fill_ch1_ready", 32'(enq_ready[1]), 32'd1);

    // Reserve twice, then an over-limit reserve
    reserve[0] = 1'b1;
    cyc();
    check("la_pend_1", 32'(pending_count[0]), 32'd1);
    check("la_tag_1", 32'(lookahead_tag[0]), 32'd2);
    cyc();
    check("la_pend_2", 32'(pending_count[0]), 32'd2);
    check("la_tag_2", 32'(lookahead_tag[0]), 32'd3);
    check("la_err_0", 32'(protocol_error[0]), 32'd0);
    cyc();
    reserve[0] = 1'b0;
    check("la_pend_ovf", 32'(pending_count[0]), 32'd2);
    check("la_tag_ovf", 32'(lookahead_tag[0]), 32'd3);
    check("la_err_1", 32'(protocol_error[0]), 32'd1);
    check("la_err_ch1", 32'(protocol_error[1]), 32'd0);

    // Reserve + commit in the same cycle
    do_reset();
    check("rc_err_clr", 32'(protocol_error[0]), 32'd0);
    for (int t = 1; t <= 3; t++) enq0(t);
    reserve[0] = 1'b1;
    cyc();
    commit[0] = 1'b1;
    cyc();
    reserve[0] = 1'b0;
    commit[0]  = 1'b0;
    check("rc_pend", 32'(pending_count[0]), 32'd1);
    check("rc_head", 32'(head_tag[0]), 32'd2);
    check("rc_la_tag", 32'(lookahead_tag[0]), 32'd3);
    check("rc_la_valid", 32'(lookahead_valid[0]), 32'd1);
    commit[0] = 1'b1;
    cyc();
    commit[0] = 1'b0;
    check("rc_head_after", 32'(head_tag[0]), 32'd3);
    reserve[0] = 1'b1;
    cyc();
    reserve[0] = 1'b0;
    // One entry left and now reserved: count was 2 before the commit
    check("rc_count_probe", 32'(lookahead_valid[0]), 32'd0);
    check("rc_err", 32'(protocol_error[0]), 32'd0);

    // Flush with pending=2 and a same-cycle commit
    do_reset();
    for (int t = 5; t <= 7; t++) enq0(t);
    reserve[0] = 1'b1;
    cyc();
    cyc();
    reserve[0] = 1'b0;
    check("fl_pend_pre", 32'(pending_count[0]), 32'd2);
    check("fl_la_pre", 32'(lookahead_tag[0]), 32'd7);
    flush     = 1'b1;
    commit[0] = 1'b1;
    cyc();
    flush     = 1'b0;
    commit[0] = 1'b0;
    check("fl_pend", 32'(pending_count[0]), 32'd0);
    check("fl_head", 32'(head_tag[0]), 32'd6);
    check("fl_la_tag", 32'(lookahead_tag[0]), 32'd6);
    check("fl_err", 32'(protocol_error[0]), 32'd0);
    flush      = 1'b1;
    reserve[0] = 1'b1;
    cyc();
    flush      = 1'b0;
    reserve[0] = 1'b0;
    check("fl_res_supp", 32'(pending_count[0]), 32'd0);
    check("fl_res_err", 32'(protocol_error[0]), 32'd0);

    // Streaming across pointer wrap: steady state count=2, pending=1
    do_reset();
    for (int k = 0; k < 10; k++) begin
      enq_valid[0] = 1'b1;
      enq_tag[0]   = TW'(k);
      enq_data[0]  = WW'(k * 100);
      reserve[0]   = (k >= 1);
      commit[0]    = (k >= 2);
      cyc();
      if (k >= 1) begin
        check($sformatf("wrap_head_%0d", k), 32'(head_tag[0]), 32'(k - 1));
        check($sformatf("wrap_pend_%0d", k), 32'(pending_count[0]), 32'd1);
      end
    end
    enq_valid[0] = 1'b0;
    cyc();
    check("wrap_head_9", 32'(head_tag[0]), 32'd9);
    check("wrap_data_9", head_data[0], 32'd900);
    reserve[0] = 1'b0;
    cyc();
    commit[0] = 1'b0;
    check("wrap_la_empty", 32'(lookahead_valid[0]), 32'd0);
    check("wrap_pend_end", 32'(pending_count[0]), 32'd0);
    check("wrap_err", 32'(protocol_error[0]), 32'd0);

    // Asynchronous reset landing between edges mid-burst
    do_reset();
    enq_valid = 4'b0011;
    enq_tag   = '0;
    cyc();
    enq_valid  = 4'b0011;
    reserve    = 4'b0001;
    commit     = 4'b0100;
    cyc();
    check("ar_pre_pend", 32'(pending_count[0]), 32'd1);
    check("ar_pre_err", 32'(protocol_error), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check("ar_enq_ready", 32'(enq_ready), 32'hF);
    check("ar_la_valid", 32'(lookahead_valid), 32'h0);
    check("ar_pending", 32'(pending_count), 32'h0);
    check("ar_err", 32'(protocol_error), 32'h0);
    idle();
    cyc();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
